id_rr_hazard_ctrl: RTL and testbench

//  Sequences the ID->RR pipeline register: decides each cycle whether the decoded instruction issues,

---
 rtl/id_rr_hazard_ctrl_if.sv | 37 +++
 rtl/id_rr_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_id_rr_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_rr_hazard_ctrl_if.sv
// Decode/RR hazard-control bus: decoded instruction, backpressure, redirect, writeback releases
// and the resulting ID/RR register controls.
interface id_rr_hazard_ctrl_if #(
  parameter int NREG  = 8,
  parameter int IDX_W = $clog2(NREG)
);
  logic             id_valid;
  logic [IDX_W-1:0] id_src1_idx;
  logic             id_src1_use;
  logic [IDX_W-1:0] id_src2_idx;
  logic             id_src2_use;
  logic [IDX_W-1:0] id_dst_idx;
  logic             id_dst_we;
  logic             ext_stall;
  logic             redirect_valid;
  logic             wb_valid;
  logic [IDX_W-1:0] wb_idx;
  logic             issue;
  logic             id_hold;
  logic             rr_stall;
  logic             flush;
  logic [NREG-1:0]  busy_vec;
  logic             recovering;
  logic             sb_err;

  modport master (
    output id_valid, id_src1_idx, id_src1_use, id_src2_idx, id_src2_use,
           id_dst_idx, id_dst_we, ext_stall, redirect_valid, wb_valid, wb_idx,
    input  issue, id_hold, rr_stall, flush, busy_vec, recovering, sb_err
  );

  modport slave (
    input  id_valid, id_src1_idx, id_src1_use, id_src2_idx, id_src2_use,
           id_dst_idx, id_dst_we, ext_stall, redirect_valid, wb_valid, wb_idx,
    output issue, id_hold, rr_stall, flush, busy_vec, recovering, sb_err
  );
endinterface

// File: rtl/id_rr_hazard_ctrl.sv
// ID->RR issue control: per-GPR pending-write scoreboard, RAW/saturation holds and a
// redirect recovery FSM that flushes ID/RR and blocks issue while fetch refills.
module id_rr_hazard_ctrl #(
  parameter int NREG          = 8,
  parameter int CNT_W         = 2,
  parameter int REFILL_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_bar,
  id_rr_hazard_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NREG);
  localparam int RC_W  = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [RC_W-1:0]  refill_q, refill_d;
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic             sv_q, sv_d;
  logic [IDX_W-1:0] sidx_q, sidx_d;
  logic             sb_err_q, sb_err_d;

  logic [NREG-1:0]  busy;
  logic             flush, raw, sat, in_run, issue, rr_stall;

  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++) busy[r] = (cnt_q[r] != '0);
  end

  // Writebacks in the same cycle are not bypassed: hazards look only at registered counts.
  assign flush    = bus.redirect_valid;
  assign raw      = (bus.id_src1_use & busy[bus.id_src1_idx]) |
                    (bus.id_src2_use & busy[bus.id_src2_idx]);
  assign sat      = bus.id_dst_we & (cnt_q[bus.id_dst_idx] == CNT_MAX);
  assign in_run   = (state_q == ST_RUN);
  assign issue    = in_run & bus.id_valid & ~raw & ~sat & ~bus.ext_stall & ~flush;
  assign rr_stall = bus.ext_stall & ~flush;

  assign bus.issue      = issue;
  assign bus.id_hold    = in_run & bus.id_valid & (raw | sat | bus.ext_stall) & ~flush;
  assign bus.rr_stall   = rr_stall;
  assign bus.flush      = flush;
  assign bus.busy_vec   = busy;
  assign bus.recovering = (state_q == ST_RECOVER);
  assign bus.sb_err     = sb_err_q;

  // Any redirect (re)arms the refill countdown; RUN resumes once it expires.
  always_comb begin
    state_d  = state_q;
    refill_d = refill_q;
    if (flush) begin
      state_d  = ST_RECOVER;
      refill_d = RC_W'(REFILL_CYCLES);
    end else if (state_q == ST_RECOVER) begin
      if (refill_q <= RC_W'(1)) begin
        state_d  = ST_RUN;
        refill_d = '0;
      end else begin
        refill_d = refill_q - 1'b1;
      end
    end
  end

  always_comb begin
    sv_d   = sv_q;
    sidx_d = sidx_q;
    if (flush) begin
      sv_d = 1'b0;
    end else if (!rr_stall) begin
      sv_d   = issue & bus.id_dst_we;
      sidx_d = bus.id_dst_idx;
    end
  end

  // A flushed RR instruction never reaches writeback, so it releases its own pending write.
  logic [CNT_W:0] up, diff;
  logic [1:0]     dn;
  always_comb begin
    sb_err_d = sb_err_q;
    up       = '0;
    dn       = '0;
    diff     = '0;
    for (int r = 0; r < NREG; r++) begin
      up = {1'b0, cnt_q[r]} +
           (CNT_W+1)'(issue & bus.id_dst_we & (bus.id_dst_idx == IDX_W'(r)));
      dn = {1'b0, bus.wb_valid & (bus.wb_idx == IDX_W'(r))} +
           {1'b0, flush & sv_q & (sidx_q == IDX_W'(r))};
      if ((CNT_W+1)'(dn) > up) begin
        sb_err_d = 1'b1;
        cnt_d[r] = '0;
      end else begin
        diff     = up - (CNT_W+1)'(dn);
        cnt_d[r] = diff[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q  <= ST_RUN;
      refill_q <= '0;
      sv_q     <= 1'b0;
      sidx_q   <= '0;
      sb_err_q <= 1'b0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      state_q  <= state_d;
      refill_q <= refill_d;
      sv_q     <= sv_d;
      sidx_q   <= sidx_d;
      sb_err_q <= sb_err_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end
endmodule

// File: tb/tb_id_rr_hazard_ctrl.sv
// Self-checking bench for id_rr_hazard_ctrl: directed hazard/redirect scenarios followed by
// random traffic, all compared against a counting model of the scoreboard rules.
module tb_id_rr_hazard_ctrl;
  localparam int NREG   = 8;
  localparam int REFILL = 2;

  logic clk = 1'b0;
  logic rst_bar = 1'b0;
  int   total = 0;
  int   bad = 0;

  id_rr_hazard_ctrl_if #(.NREG(NREG)) bus ();

  id_rr_hazard_ctrl #(.NREG(NREG), .CNT_W(2), .REFILL_CYCLES(REFILL)) dut (
    .clk(clk), .rst_bar(rst_bar), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending-write counts, remaining recovery cycles, occupant of RR.
  int   mCnt [NREG];
  int   mRecLeft;
  bit   mSv;
  int   mSidx;
  bit   mErr;

  logic cV, cU1, cU2, cWe, cEs, cRd, cWbv;
  logic [2:0] cS1, cS2, cD, cWbi;
  logic eIssue, eHold, eStall, eFlush, eRec, eErr;
  logic [7:0] eBusy;

  task automatic resetModel();
    for (int r = 0; r < NREG; r++) mCnt[r] = 0;
    mRecLeft = 0;
    mSv = 0;
    mSidx = 0;
    mErr = 0;
  endtask

  task automatic computeExpected();
    bit rec, raw, sat;
    rec = (mRecLeft > 0);
    raw = (cU1 && mCnt[cS1] > 0) || (cU2 && mCnt[cS2] > 0);
    sat = cWe && (mCnt[cD] == 3);
    eFlush = cRd;
    eIssue = !rec && cV && !raw && !sat && !cEs && !cRd;
    eHold  = !rec && cV && (raw || sat || cEs) && !cRd;
    eStall = cEs && !cRd;
    eRec   = rec;
    eErr   = mErr;
    for (int r = 0; r < NREG; r++) eBusy[r] = (mCnt[r] > 0);
  endtask

  task automatic updateModel();
    int n;
    for (int r = 0; r < NREG; r++) begin
      n = mCnt[r];
      if (eIssue && cWe && cD == r) n++;
      if (cWbv && cWbi == r) n--;
      if (cRd && mSv && mSidx == r) n--;
      if (n < 0) begin
        mErr = 1;
        n = 0;
      end
      mCnt[r] = n;
    end
    if (cRd) mSv = 0;
    else if (!eStall) begin
      mSv = eIssue && cWe;
      mSidx = cD;
    end
    if (cRd) mRecLeft = REFILL;
    else if (mRecLeft > 0) mRecLeft--;
  endtask

  task automatic checkOne(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(string tag);
    checkOne({tag, ".issue"},      8'(bus.issue),      8'(eIssue));
    checkOne({tag, ".id_hold"},    8'(bus.id_hold),    8'(eHold));
    checkOne({tag, ".rr_stall"},   8'(bus.rr_stall),   8'(eStall));
    checkOne({tag, ".flush"},      8'(bus.flush),      8'(eFlush));
    checkOne({tag, ".busy_vec"},   bus.busy_vec,       eBusy);
    checkOne({tag, ".recovering"}, 8'(bus.recovering), 8'(eRec));
    checkOne({tag, ".sb_err"},     8'(bus.sb_err),     8'(eErr));
  endtask

  task automatic drive();
    bus.id_valid = cV;   bus.id_src1_idx = cS1; bus.id_src1_use = cU1;
    bus.id_src2_idx = cS2; bus.id_src2_use = cU2;
    bus.id_dst_idx = cD; bus.id_dst_we = cWe;   bus.ext_stall = cEs;
    bus.redirect_valid = cRd; bus.wb_valid = cWbv; bus.wb_idx = cWbi;
  endtask

  // Entered 1 time unit after a rising edge; checks mid-cycle and returns just after the next edge.
  task automatic applyStimulus(input logic v, input logic [2:0] s1, input logic u1,
                               input logic [2:0] s2, input logic u2, input logic [2:0] d,
                               input logic we, input logic es, input logic rd,
                               input logic wbv, input logic [2:0] wbi, input string tag);
    cV = v; cS1 = s1; cU1 = u1; cS2 = s2; cU2 = u2; cD = d; cWe = we;
    cEs = es; cRd = rd; cWbv = wbv; cWbi = wbi;
    drive();
    #4;
    computeExpected();
    checkOutput(tag);
    updateModel();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse(input string tag);
    cV = 0; cS1 = 0; cU1 = 0; cS2 = 0; cU2 = 0; cD = 0; cWe = 0;
    cEs = 0; cRd = 0; cWbv = 0; cWbi = 0;
    drive();
    rst_bar = 1'b0;
    #1;
    resetModel();
    computeExpected();
    checkOutput(tag);
    rst_bar = 1'b1;
    #1;
  endtask

  task automatic issueWrite(input logic [2:0] d, input string tag);
    applyStimulus(1, 0, 0, 0, 0, d, 1, 0, 0, 0, 0, tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    logic v, u1, u2, we, es, rd, wbv;
    logic [2:0] s1, s2, d, wbi;
    int k;
    cV = 0; cS1 = 0; cU1 = 0; cS2 = 0; cU2 = 0; cD = 0; cWe = 0;
    cEs = 0; cRd = 0; cWbv = 0; cWbi = 0;
    drive();
    resetModel();
    @(posedge clk);
    #1;
    resetPulse("por");

    // RAW on r3: held, wb in the same cycle does not bypass, issue the cycle after
    issueWrite(3, "raw_wr");
    applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, "raw_hold");
    applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 3, "raw_wb");
    applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, "raw_go");

    // Reset during RECOVER with cnt[2]=2
    issueWrite(2, "mid_w1");
    issueWrite(2, "mid_w2");
    idle("mid_idle");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "mid_redir");
    idle("mid_rec");
    resetPulse("mid_reset");

    // Saturation on r5
    issueWrite(5, "sat_w1");
    issueWrite(5, "sat_w2");
    issueWrite(5, "sat_w3");
    applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 5, "sat_hold_wb");
    issueWrite(5, "sat_go");
    issueWrite(5, "sat_full");

    // Flush self-release of r1 with backpressure present
    issueWrite(1, "fl_wr");
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, "fl_redir");
    issueWrite(2, "fl_rec1");
    issueWrite(2, "fl_rec2");
    issueWrite(2, "fl_run");

    // Simultaneous inc/dec on r4, then a redirect that restarts recovery
    issueWrite(4, "sim_w");
    applyStimulus(1, 0, 0, 0, 0, 4, 1, 0, 0, 1, 4, "sim_both");
    applyStimulus(1, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0, "sim_redir");
    idle("sim_rec1");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "sim_redir2");
    idle("sim_rec2");
    idle("sim_rec3");
    idle("sim_run");

    // Random traffic; releases only target registers with pending writes
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(3) != 0);
      s1 = 3'($urandom_range(7)); u1 = 1'($urandom_range(1));
      s2 = 3'($urandom_range(7)); u2 = 1'($urandom_range(1));
      d  = 3'($urandom_range(7)); we = ($urandom_range(3) != 0);
      es = ($urandom_range(3) == 0);
      rd = ($urandom_range(11) == 0);
      wbv = 0;
      wbi = 3'($urandom_range(7));
      if ($urandom_range(1) == 1) begin
        for (int j = 0; j < NREG; j++) begin
          k = (int'(wbi) + j) % NREG;
          if (!wbv && mCnt[k] > 0 && !(rd && mSv && mSidx == k && mCnt[k] == 1)) begin
            wbv = 1;
            wbi = 3'(k);
          end
        end
      end
      applyStimulus(v, s1, u1, s2, u2, d, we, es, rd, wbv, wbi, "rand");
    end

    // Releasing an idle register is a sticky protocol error
    resetPulse("err_reset");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, "err_wb");
    idle("err_sticky1");
    issueWrite(6, "err_sticky2");
    idle("err_sticky3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
